// File: rtl/mips_mem_responder.sv
// Memory responder for the byte-wide multicycle MIPS bus: RAM plus a boot loader FSM.
// Define MEM_WRPROT_EN to discard processor writes below TEXT_TOP and flag them on wr_err.
module mips_mem_responder #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ADDRBITS = 8,
  parameter int unsigned TEXT_TOP = 'h40
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                memread,
  input  logic                memwrite,
  input  logic [ADDRBITS-1:0] adr,
  input  logic [WIDTH-1:0]    writedata,
  output logic [WIDTH-1:0]    memdata,
  output logic                cpu_reset,
  input  logic                ld_valid,
  input  logic [WIDTH-1:0]    ld_data,
  input  logic                ld_last,
  output logic                ld_ready,
  output logic                wr_err
);

  localparam int unsigned DEPTH = 1 << ADDRBITS;
  localparam logic [ADDRBITS-1:0] TEXT_TOP_A = ADDRBITS'(TEXT_TOP);
`ifdef MEM_WRPROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {LOAD, DONE, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDRBITS-1:0] ld_ptr_q, ld_ptr_d;
  logic                wr_err_q, wr_err_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];

  logic                mem_we;
  logic [ADDRBITS-1:0] mem_wa;
  logic [WIDTH-1:0]    mem_wd;
  logic                ptr_full;

  assign ptr_full = (ld_ptr_q == {ADDRBITS{1'b1}});

  always_comb begin
    state_d   = state_q;
    ld_ptr_d  = ld_ptr_q;
    wr_err_d  = wr_err_q;
    mem_we    = 1'b0;
    mem_wa    = ld_ptr_q;
    mem_wd    = ld_data;
    ld_ready  = 1'b0;
    cpu_reset = 1'b1;
    memdata   = '0;
    if (reset) begin
      state_d  = LOAD;
      ld_ptr_d = '0;
      wr_err_d = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          ld_ready = 1'b1;
          if (ld_valid) begin
            mem_we = 1'b1;
            // Pointer holds on the last slot so a full image never wraps.
            ld_ptr_d = ptr_full ? ld_ptr_q : ld_ptr_q + 1'b1;
            if (ld_last || ptr_full) state_d = DONE;
          end
        end
        DONE: state_d = RUN;
        RUN: begin
          cpu_reset = 1'b0;
          // Read returns the pre-write word when a write hits the same cycle.
          if (memread) memdata = mem_q[adr];
          if (memwrite) begin
            if (PROT_EN && (adr < TEXT_TOP_A)) begin
              wr_err_d = 1'b1;
            end else begin
              mem_we = 1'b1;
              mem_wa = adr;
              mem_wd = writedata;
            end
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  assign wr_err = wr_err_q & ~reset;

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    ld_ptr_q <= ld_ptr_d;
    wr_err_q <= wr_err_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: boot load, processor access, reset and write protection.
module tb_mips_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       memread, memwrite;
  logic [7:0] adr, writedata, memdata;
  logic       cpu_reset;
  logic       ld_valid, ld_last, ld_ready, wr_err;
  logic [7:0] ld_data;

  int checks = 0;
  int errors = 0;

  mips_mem_responder #(.WIDTH(8), .ADDRBITS(8), .TEXT_TOP('h40)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite), .adr(adr),
    .writedata(writedata), .memdata(memdata), .cpu_reset(cpu_reset), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    memread = 1'b1;
    adr     = a;
    #1;
    chk(tag, {24'h0, memdata}, {24'h0, exp});
    memread = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    memwrite  = 1'b1;
    adr       = a;
    writedata = d;
    step();
    memwrite  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; adr = '0; writedata = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;

    // 1: reset outputs, then a 4-byte image
    step(); step();
    memread = 1'b1; #1;
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_memdata", memdata, 0);
    chk("rst_wr_err", wr_err, 0);
    memread = 1'b0;
    reset = 1'b0; #1;
    chk("load_ld_ready", ld_ready, 1);
    chk("load_cpu_reset", cpu_reset, 1);
    load_byte(8'h80, 0); load_byte(8'h02, 0); load_byte(8'h00, 0); load_byte(8'h0A, 1);
    chk("done_ld_ready", ld_ready, 0);
    chk("done_cpu_reset", cpu_reset, 1);
    step();
    chk("run_cpu_reset", cpu_reset, 0);
    chk("run_ld_ready", ld_ready, 0);
    rd_chk("t1_rd0", 8'h00, 8'h80);
    rd_chk("t1_rd1", 8'h01, 8'h02);
    rd_chk("t1_rd2", 8'h02, 8'h00);
    rd_chk("t1_rd3", 8'h03, 8'h0A);

    // 2: gaps in ld_valid do not write or advance the pointer
    do_reset();
    load_byte(8'h11, 0);
    ld_data = 8'h99; step();
    load_byte(8'h22, 0);
    ld_data = 8'h99; step();
    load_byte(8'h33, 1);
    step();
    rd_chk("t2_rd0", 8'h00, 8'h11);
    rd_chk("t2_rd1", 8'h01, 8'h22);
    rd_chk("t2_rd2", 8'h02, 8'h33);
    rd_chk("t2_rd3_kept", 8'h03, 8'h0A);

    // 3: processor writes, read-during-write returns old data
    wr(8'h50, 8'hA5);
    rd_chk("t3_rd50", 8'h50, 8'hA5);
    wr(8'h51, 8'h00);
    memread = 1'b1; memwrite = 1'b1; adr = 8'h51; writedata = 8'h3C; #1;
    chk("t3_rdwr_old", memdata, 8'h00);
    step();
    memwrite = 1'b0; #1;
    chk("t3_rdwr_new", memdata, 8'h3C);
    memread = 1'b0; #1;
    chk("t3_no_read", memdata, 0);

    // 4: full 256-byte image ends the load without wrapping
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) chk("t4_ready_before_last", ld_ready, 1);
      load_byte(8'(i + 'h30), 0);
    end
    chk("t4_done_ld_ready", ld_ready, 0);
    chk("t4_done_cpu_reset", cpu_reset, 1);
    ld_valid = 1'b1; ld_data = 8'hEE; step();
    ld_valid = 1'b0;
    chk("t4_run_cpu_reset", cpu_reset, 0);
    rd_chk("t4_rd00", 8'h00, 8'h30);
    rd_chk("t4_rd80", 8'h80, 8'hB0);
    rd_chk("t4_rdff", 8'hFF, 8'h2F);

    // 5: reset mid-load; processor strobes ignored while loading
    do_reset();
    memread = 1'b1; memwrite = 1'b1; adr = 8'h05; writedata = 8'hEE; #1;
    chk("t5_load_memdata", memdata, 0);
    load_byte(8'hAA, 0);
    memread = 1'b0; memwrite = 1'b0;
    load_byte(8'hBB, 0); load_byte(8'hCC, 0);
    reset = 1'b1; step();
    chk("t5_rst_cpu_reset", cpu_reset, 1);
    chk("t5_rst_ld_ready", ld_ready, 0);
    reset = 1'b0; #1;
    chk("t5_reload_ready", ld_ready, 1);
    load_byte(8'hDD, 1);
    step();
    chk("t5_run_cpu_reset", cpu_reset, 0);
    rd_chk("t5_rd0", 8'h00, 8'hDD);
    rd_chk("t5_rd1", 8'h01, 8'hBB);
    rd_chk("t5_rd2", 8'h02, 8'hCC);
    rd_chk("t5_rd5", 8'h05, 8'h35);

    // 6: writes below the text boundary
    wr(8'h10, 8'hFF);
`ifdef MEM_WRPROT_EN
    chk("t6_wr_err_set", wr_err, 1);
    rd_chk("t6_rd10", 8'h10, 8'h40);
`else
    chk("t6_wr_err_set", wr_err, 0);
    rd_chk("t6_rd10", 8'h10, 8'hFF);
`endif
    wr(8'h40, 8'h77);
    rd_chk("t6_rd40", 8'h40, 8'h77);
`ifdef MEM_WRPROT_EN
    chk("t6_wr_err_sticky", wr_err, 1);
`else
    chk("t6_wr_err_sticky", wr_err, 0);
`endif
    reset = 1'b1; #1;
    chk("t6_rst_wr_err", wr_err, 0);
    step();
    reset = 1'b0; #1;
    chk("t6_post_rst_wr_err", wr_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
